// File: rtl/keccak_pkg.sv
// Shared constants and types for the Keccak sponge front-end.
package keccak_pkg;
   localparam int unsigned LANES               = 25;
   localparam int unsigned RATE_LANES_SHA3_256 = 17;
   localparam logic [7:0]  DOMAIN_SHA3         = 8'h06;
   localparam logic [7:0]  PAD_END             = 8'h80;

   typedef enum logic [1:0] {ABSORB, PAD, CAP} state_e;

   typedef logic [63:0] lane_t;
endpackage

// File: rtl/keccak_pad_lane.sv
// Composes one padded rate lane: kept message bytes, optional domain byte,
// optional end-of-rate 0x80 marker in the top byte.
module keccak_pad_lane
   import keccak_pkg::*;
#(
   parameter int unsigned RATE_LANES = RATE_LANES_SHA3_256,
   parameter logic [7:0]  DOMAIN     = DOMAIN_SHA3,
   parameter int unsigned LW         = 5
) (
   input  lane_t          part_i,
   input  logic [3:0]     vcnt_i,
   input  logic [LW-1:0]  lane_idx_i,
   input  logic           pad_start_i,
   input  logic           last_rate_i,
   output lane_t          lane_o
);

   always_comb begin
      lane_o = '0;
      for (int k = 0; k < 8; k++) begin
         if (4'(k) < vcnt_i) begin
            lane_o[8*k +: 8] = part_i[8*k +: 8];
         end else if ((4'(k) == vcnt_i) && pad_start_i) begin
            lane_o[8*k +: 8] = DOMAIN;
         end
      end
      // the end marker only closes a block that also carries the domain byte
      if (last_rate_i && (lane_idx_i == LW'(RATE_LANES - 1))) begin
         lane_o[63:56] = lane_o[63:56] | PAD_END;
      end
   end

endmodule

// File: rtl/keccak_pad_blk.sv
// Byte-to-lane packer with SHA-3 multi-rate padding; emits 25-lane blocks
// (rate lanes then zero capacity lanes) towards the permutation.
module keccak_pad_blk
   import keccak_pkg::*;
#(
   parameter int unsigned RATE_LANES = RATE_LANES_SHA3_256,
   parameter logic [7:0]  DOMAIN     = DOMAIN_SHA3
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        pushin,
   output logic        stopin,
   input  logic        firstin,
   input  logic        lastin,
   input  logic [7:0]  din,
   output logic        pushout,
   input  logic        stopout,
   output logic        firstout,
   output logic [63:0] dout
);

   localparam int unsigned LW        = $clog2(LANES);
   localparam int unsigned CAP_LANES = LANES - RATE_LANES;

   state_e         state_q;
   lane_t          obuf_q;
   lane_t          part_q;
   logic           pushout_q;
   logic           firstout_q;
   logic [2:0]     byte_idx_q;
   logic [3:0]     vcnt_q;
   logic [LW-1:0]  lane_idx_q;
   logic [LW-1:0]  cap_cnt_q;
   logic           msg_first_q;
   logic           pad_owed_q;

   logic  obuf_free;
   logic  accept;
   logic  first_now;
   logic  last_lane;
   logic  pad_here;
   logic  closes;
   lane_t full_lane;
   lane_t pad_lane;

   assign stopin    = (state_q != ABSORB) || (pushout_q && stopout && (byte_idx_q == 3'd7));
   assign accept    = pushin && !stopin;
   assign obuf_free = !pushout_q || !stopout;
   assign first_now = msg_first_q || (accept && firstin);
   assign last_lane = (lane_idx_q == LW'(RATE_LANES - 1));
   // domain byte still owed and it fits in the current lane
   assign pad_here  = pad_owed_q && (vcnt_q < 4'd8);
   assign closes    = pad_here || !pad_owed_q;

   always_comb begin
      full_lane = part_q;
      full_lane[{byte_idx_q, 3'b000} +: 8] = din;
   end

   keccak_pad_lane #(
      .RATE_LANES (RATE_LANES),
      .DOMAIN     (DOMAIN),
      .LW         (LW)
   ) u_pad_lane (
      .part_i      (part_q),
      .vcnt_i      (vcnt_q),
      .lane_idx_i  (lane_idx_q),
      .pad_start_i (pad_here),
      .last_rate_i (closes),
      .lane_o      (pad_lane)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ABSORB;
         obuf_q      <= '0;
         part_q      <= '0;
         pushout_q   <= 1'b0;
         firstout_q  <= 1'b0;
         byte_idx_q  <= '0;
         vcnt_q      <= '0;
         lane_idx_q  <= '0;
         cap_cnt_q   <= '0;
         msg_first_q <= 1'b0;
         pad_owed_q  <= 1'b0;
      end else begin
         if (pushout_q && !stopout) begin
            pushout_q <= 1'b0;
         end
         if (accept && firstin) begin
            msg_first_q <= 1'b1;
         end
         case (state_q)
            ABSORB: begin
               if (accept) begin
                  part_q     <= full_lane;
                  byte_idx_q <= byte_idx_q + 3'd1;
                  if (lastin) begin
                     // even a full final lane goes through PAD so padding decides its top byte
                     vcnt_q     <= {1'b0, byte_idx_q} + 4'd1;
                     pad_owed_q <= 1'b1;
                     byte_idx_q <= '0;
                     state_q    <= PAD;
                  end else if (byte_idx_q == 3'd7) begin
                     obuf_q     <= full_lane;
                     pushout_q  <= 1'b1;
                     firstout_q <= first_now && (lane_idx_q == '0);
                     if (lane_idx_q == '0) begin
                        msg_first_q <= 1'b0;
                     end
                     if (last_lane) begin
                        lane_idx_q <= '0;
                        cap_cnt_q  <= '0;
                        state_q    <= CAP;
                     end else begin
                        lane_idx_q <= lane_idx_q + LW'(1);
                     end
                  end
               end
            end
            PAD: begin
               if (obuf_free) begin
                  obuf_q     <= pad_lane;
                  pushout_q  <= 1'b1;
                  firstout_q <= msg_first_q && (lane_idx_q == '0);
                  if (lane_idx_q == '0) begin
                     msg_first_q <= 1'b0;
                  end
                  vcnt_q <= '0;
                  if (pad_here) begin
                     pad_owed_q <= 1'b0;
                  end
                  if (last_lane) begin
                     lane_idx_q <= '0;
                     cap_cnt_q  <= '0;
                     state_q    <= CAP;
                  end else begin
                     lane_idx_q <= lane_idx_q + LW'(1);
                  end
               end
            end
            CAP: begin
               if (obuf_free) begin
                  obuf_q     <= '0;
                  pushout_q  <= 1'b1;
                  firstout_q <= 1'b0;
                  if (cap_cnt_q == LW'(CAP_LANES - 1)) begin
                     state_q <= pad_owed_q ? PAD : ABSORB;
                  end else begin
                     cap_cnt_q <= cap_cnt_q + LW'(1);
                  end
               end
            end
            default: state_q <= ABSORB;
         endcase
      end
   end

   assign pushout  = pushout_q;
   assign firstout = firstout_q;
   assign dout     = obuf_q;

endmodule
